// File: rtl/dpi_pkg.sv
// rtl/dpi_pkg.sv - shared types and constants for the DPI packet sequencer
package dpi_pkg;

    localparam int STREAM_ID_W  = 6;
    localparam int NUM_STREAMS  = 64;
    localparam int DEF_LOAD_GAP = 2;
    localparam int DEF_EOP_GAP  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_LOAD,
        ST_PRIME,
        ST_STREAM,
        ST_DRAIN,
        ST_EOP,
        ST_RESULT
    } seq_state_t;

endpackage

// File: rtl/dpi_flow_table.sv
// rtl/dpi_flow_table.sv - 64-entry associative flow-key store with FIFO allocation
module dpi_flow_table
    import dpi_pkg::*;
#(
    parameter int KEY_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [KEY_W-1:0]       i_lookup_key,
    output logic                   o_hit,
    output logic [STREAM_ID_W-1:0] o_hit_idx,
    input  logic                   i_alloc_en,
    input  logic [KEY_W-1:0]       i_alloc_key,
    output logic [STREAM_ID_W-1:0] o_alloc_ptr
);

    logic [KEY_W-1:0]       r_keys [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] r_valid;
    logic [STREAM_ID_W-1:0] r_alloc_ptr;

    // The pointer wraps naturally, so a full table evicts the oldest entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid     <= '0;
            r_alloc_ptr <= '0;
        end else if (i_alloc_en) begin
            r_valid[r_alloc_ptr] <= 1'b1;
            r_alloc_ptr          <= r_alloc_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_alloc_en) begin
            r_keys[r_alloc_ptr] <= i_alloc_key;
        end
    end

    always_comb begin
        o_hit     = 1'b0;
        o_hit_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_keys[i] == i_lookup_key)) begin
                o_hit     = 1'b1;
                o_hit_idx = STREAM_ID_W'(i);
            end
        end
    end

    assign o_alloc_ptr = r_alloc_ptr;

endmodule

// File: rtl/dpi_pkt_sequencer.sv
// rtl/dpi_pkt_sequencer.sv - maps flow keys to stream ids and drives the matcher bank protocol
module dpi_pkt_sequencer
    import dpi_pkg::*;
#(
    parameter int NUM_REGEX = 8,
    parameter int KEY_W     = 32,
    parameter int LOAD_GAP  = DEF_LOAD_GAP,
    parameter int EOP_GAP   = DEF_EOP_GAP
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_pkt_valid,
    output logic                   o_pkt_ready,
    input  logic [7:0]             i_pkt_data,
    input  logic                   i_pkt_sop,
    input  logic                   i_pkt_eop,
    input  logic [KEY_W-1:0]       i_pkt_key,
    input  logic [NUM_REGEX-1:0]   i_cfg_enable,
    output logic [7:0]             o_char_in,
    output logic                   o_char_in_vld,
    output logic                   o_load_state,
    output logic                   o_new_stream_id,
    output logic [STREAM_ID_W-1:0] o_stream_id,
    output logic                   o_eop,
    output logic [NUM_REGEX-1:0]   o_enable,
    input  logic [NUM_REGEX-1:0]   i_fired,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [NUM_REGEX-1:0]   o_res_match,
    output logic [STREAM_ID_W-1:0] o_res_stream_id
);

    localparam int GAP_W = 8;

    seq_state_t             r_state;
    seq_state_t             w_next;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [STREAM_ID_W-1:0] r_stream_id;
    logic [STREAM_ID_W-1:0] r_res_stream_id;
    logic [STREAM_ID_W-1:0] w_hit_idx;
    logic [STREAM_ID_W-1:0] w_alloc_ptr;
    logic                   r_new_stream_id;
    logic                   w_hit;
    logic                   w_alloc_en;
    logic                   w_last_beat;
    logic [NUM_REGEX-1:0]   r_enable;
    logic [NUM_REGEX-1:0]   r_res_match;

    assign w_last_beat = (r_state == ST_STREAM) && i_pkt_valid && i_pkt_eop;
    assign w_alloc_en  = (r_state == ST_LOOKUP) && !w_hit;

    dpi_flow_table #(
        .KEY_W(KEY_W)
    ) u_flow_table (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_lookup_key (i_pkt_key),
        .o_hit        (w_hit),
        .o_hit_idx    (w_hit_idx),
        .i_alloc_en   (w_alloc_en),
        .i_alloc_key  (i_pkt_key),
        .o_alloc_ptr  (w_alloc_ptr)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_pkt_valid && i_pkt_sop) w_next = ST_LOOKUP;
            ST_LOOKUP: w_next = ST_LOAD;
            ST_LOAD:   w_next = (LOAD_GAP > 0) ? ST_PRIME : ST_STREAM;
            ST_PRIME:  if (r_gap_cnt == '0) w_next = ST_STREAM;
            ST_STREAM: if (w_last_beat) w_next = (EOP_GAP > 0) ? ST_DRAIN : ST_EOP;
            ST_DRAIN:  if (r_gap_cnt == '0) w_next = ST_EOP;
            ST_EOP:    w_next = ST_RESULT;
            ST_RESULT: if (i_res_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Stream id and enable stay frozen from LOAD through EOP; matchers commit by stream_id at eop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gap_cnt       <= '0;
            r_stream_id     <= '0;
            r_new_stream_id <= 1'b0;
            r_enable        <= '0;
            r_res_match     <= '0;
            r_res_stream_id <= '0;
        end else begin
            case (r_state)
                ST_LOOKUP: begin
                    r_enable        <= i_cfg_enable;
                    r_new_stream_id <= !w_hit;
                    r_stream_id     <= w_hit ? w_hit_idx : w_alloc_ptr;
                end
                ST_LOAD: r_gap_cnt <= GAP_W'(LOAD_GAP - 1);
                ST_PRIME, ST_DRAIN: begin
                    if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                ST_STREAM: begin
                    if (w_last_beat) r_gap_cnt <= GAP_W'(EOP_GAP - 1);
                end
                ST_EOP: begin
                    r_res_match     <= i_fired & r_enable;
                    r_res_stream_id <= r_stream_id;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_pkt_ready   = 1'b0;
        o_char_in     = '0;
        o_char_in_vld = 1'b0;
        o_load_state  = 1'b0;
        o_eop         = 1'b0;
        o_res_valid   = 1'b0;
        case (r_state)
            ST_LOAD:   o_load_state = 1'b1;
            ST_STREAM: begin
                o_pkt_ready   = 1'b1;
                o_char_in     = i_pkt_data;
                o_char_in_vld = i_pkt_valid;
            end
            ST_EOP:    o_eop = 1'b1;
            ST_RESULT: o_res_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_new_stream_id = r_new_stream_id;
    assign o_stream_id     = r_stream_id;
    assign o_enable        = r_enable;
    assign o_res_match     = r_res_match;
    assign o_res_stream_id = r_res_stream_id;

endmodule
